// File: rtl/hamming_secded_decoder.sv
// -----------------------------------------------------------------------------
// hamming_secded_decoder
//
// Serial-input decoder for the (16,11) extended Hamming SECDED code, even
// parity. Codeword bits arrive LSB first (bit 0 = overall parity, bits 1/2/4/8
// = check bits, remaining positions = data). The syndrome and overall parity
// are accumulated bit by bit. The completed word is captured into an
// evaluation stage, then corrected or flagged and loaded into a
// valid/ready-qualified output register one clock later.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   datain      serial codeword bit
//   din_valid   datain is sampled on this edge
//   data_out    corrected 11-bit data word
//   out_valid   data_out / err_single / err_double / syndrome are valid
//   out_ready   consumer accepts the word when out_valid && out_ready
//   err_single  single-bit error was corrected
//   err_double  uncorrectable double error detected
//   syndrome    raw syndrome of the held word
//   overrun     one-cycle pulse: a completed word was dropped
// -----------------------------------------------------------------------------
module hamming_secded_decoder (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        datain,
   input  logic        din_valid,
   output logic [10:0] data_out,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        err_single,
   output logic        err_double,
   output logic [3:0]  syndrome,
   output logic        overrun
);

   // Codeword positions of data_out[0] .. data_out[10].
   localparam logic [3:0] DATA_POS [0:10] = '{4'd3, 4'd5, 4'd6, 4'd7, 4'd9,
                                              4'd10, 4'd11, 4'd12, 4'd13,
                                              4'd14, 4'd15};

   // Receive state. Only data positions are stored: the check bits contribute
   // through the syndrome and parity accumulators and are never extracted.
   logic [3:0]  cnt_q,     cnt_d;
   logic [3:0]  syn_q,     syn_d;
   logic        par_q,     par_d;
   logic [10:0] rx_data_q, rx_data_d;

   // Evaluation stage, separate from the receive state so that the next word
   // can start on the edge right after bit 15.
   logic        ev_valid_q, ev_valid_d;
   logic [10:0] ev_data_q,  ev_data_d;
   logic [3:0]  ev_syn_q,   ev_syn_d;
   logic        ev_par_q,   ev_par_d;

   // Output register.
   logic [10:0] data_out_q;
   logic        out_valid_q, err_single_q, err_double_q, overrun_q;
   logic [3:0]  syndrome_q;

   logic [10:0] merged;
   logic [3:0]  syn_new;
   logic        par_new;
   logic [10:0] fixed_data;
   logic        load;

   always_comb begin
      // NOTE: every variable gets a default first, so no path can infer a latch.
      merged = rx_data_q;
      for (int j = 0; j < 11; j++) begin
         if (cnt_q == DATA_POS[j]) merged[j] = datain;
      end
      syn_new = syn_q ^ ({4{datain}} & cnt_q);
      par_new = par_q ^ datain;

      cnt_d      = cnt_q;
      syn_d      = syn_q;
      par_d      = par_q;
      rx_data_d  = rx_data_q;
      ev_valid_d = 1'b0;
      ev_data_d  = ev_data_q;
      ev_syn_d   = ev_syn_q;
      ev_par_d   = ev_par_q;

      if (din_valid) begin
         cnt_d = cnt_q + 4'd1;            // wraps 15 -> 0
         if (cnt_q == 4'd15) begin
            ev_valid_d = 1'b1;
            ev_data_d  = merged;
            ev_syn_d   = syn_new;
            ev_par_d   = par_new;
            syn_d      = 4'd0;
            par_d      = 1'b0;
            rx_data_d  = '0;
         end else begin
            syn_d     = syn_new;
            par_d     = par_new;
            rx_data_d = merged;
         end
      end
   end

   // Odd overall parity means a single error at position ev_syn_q; only data
   // positions need flipping since check bits are not part of data_out.
   always_comb begin
      fixed_data = ev_data_q;
      for (int j = 0; j < 11; j++) begin
         if (ev_par_q && (ev_syn_q == DATA_POS[j])) fixed_data[j] = ~ev_data_q[j];
      end
   end

   // A completed word may load when the register is empty or being consumed.
   assign load = ev_valid_q && (!out_valid_q || out_ready);

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: all storage, including the data holding registers, is reset so a
      // partial word or a held word never survives reset.
      if (!rst_n) begin
         cnt_q        <= 4'd0;
         syn_q        <= 4'd0;
         par_q        <= 1'b0;
         rx_data_q    <= '0;
         ev_valid_q   <= 1'b0;
         ev_data_q    <= '0;
         ev_syn_q     <= 4'd0;
         ev_par_q     <= 1'b0;
         data_out_q   <= '0;
         out_valid_q  <= 1'b0;
         err_single_q <= 1'b0;
         err_double_q <= 1'b0;
         syndrome_q   <= 4'd0;
         overrun_q    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         cnt_q      <= cnt_d;
         syn_q      <= syn_d;
         par_q      <= par_d;
         rx_data_q  <= rx_data_d;
         ev_valid_q <= ev_valid_d;
         ev_data_q  <= ev_data_d;
         ev_syn_q   <= ev_syn_d;
         ev_par_q   <= ev_par_d;
         overrun_q  <= ev_valid_q && !load;
         if (load) begin
            data_out_q   <= fixed_data;
            err_single_q <= ev_par_q;
            err_double_q <= !ev_par_q && (ev_syn_q != 4'd0);
            syndrome_q   <= ev_syn_q;
            out_valid_q  <= 1'b1;
         end else if (out_ready) begin
            out_valid_q  <= 1'b0;
         end
      end
   end

   assign data_out   = data_out_q;
   assign out_valid  = out_valid_q;
   assign err_single = err_single_q;
   assign err_double = err_double_q;
   assign syndrome   = syndrome_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// -----------------------------------------------------------------------------
// tb_hamming_secded_decoder
//
// Self-checking bench for hamming_secded_decoder. Expected results come from a
// behavioural SECDED model (syndrome = XOR of set-bit indices, parity = XOR of
// all bits) applied to whole 16-bit codewords. Inputs change 1 ns after the
// rising edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_hamming_secded_decoder;

   typedef struct packed {
      logic [10:0] data;
      logic        single;
      logic        dbl;
      logic [3:0]  syn;
   } res_t;

   logic        clk = 1'b0;
   logic        rst_n, datain, din_valid, out_ready;
   logic [10:0] data_out;
   logic        out_valid, err_single, err_double, overrun;
   logic [3:0]  syndrome;

   int   n_asserts = 0;
   int   n_fail    = 0;
   int   ovr_cnt   = 0;
   res_t got [$];

   always #5 clk = ~clk;

   hamming_secded_decoder dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .datain     (datain),
      .din_valid  (din_valid),
      .data_out   (data_out),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .err_single (err_single),
      .err_double (err_double),
      .syndrome   (syndrome),
      .overrun    (overrun)
   );

   // Inputs are stable at the falling edge, so valid && ready seen here is the
   // handshake of the following rising edge.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready)
         got.push_back({data_out, err_single, err_double, syndrome});
      if (overrun) ovr_cnt++;
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic res_t model(input logic [15:0] cw);
      res_t        r;
      int          s = 0;
      int          p = 0;
      int          k = 0;
      logic [15:0] c = cw;
      for (int i = 0; i < 16; i++) if (cw[i]) begin s ^= i; p ^= 1; end
      r.syn    = 4'(s);
      r.single = (p == 1);
      r.dbl    = (p == 0) && (s != 0);
      if (p == 1) c[s] = ~c[s];
      r.data = '0;
      for (int i = 1; i < 16; i++) begin
         if ((i & (i - 1)) != 0) begin r.data[k] = c[i]; k++; end
      end
      return r;
   endfunction

   function automatic logic [15:0] encode(input logic [10:0] d);
      logic [15:0] c = '0;
      int          k = 0;
      int          s = 0;
      for (int i = 1; i < 16; i++) begin
         if ((i & (i - 1)) != 0) begin c[i] = d[k]; k++; end
      end
      for (int i = 1; i < 16; i++) if (c[i]) s ^= i;
      for (int b = 0; b < 4; b++) c[1 << b] = s[b];
      c[0] = ^c;
      return c;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bits(input logic [15:0] cw, input bit gaps);
      for (int i = 0; i < 16; i++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 2)) begin din_valid = 1'b0; tick(); end
         end
         datain    = cw[i];
         din_valid = 1'b1;
         tick();
      end
   endtask

   task automatic send_word(input logic [15:0] cw, input bit gaps);
      send_bits(cw, gaps);
      din_valid = 1'b0;
   endtask

   task automatic expect_word(input string tag, input logic [15:0] cw);
      res_t e = model(cw);
      res_t g;
      for (int i = 0; i < 40 && got.size() == 0; i++) @(negedge clk);
      check({tag, "_present"}, 16'(got.size() != 0), 16'd1);
      if (got.size() != 0) begin
         g = got.pop_front();
         check({tag, "_data"},   16'(g.data),   16'(e.data));
         check({tag, "_single"}, 16'(g.single), 16'(e.single));
         check({tag, "_double"}, 16'(g.dbl),    16'(e.dbl));
         check({tag, "_syn"},    16'(g.syn),    16'(e.syn));
      end
   endtask

   initial begin
      logic [15:0] w1, w2, cw;
      int          p1, p2, nerr;

      rst_n = 1'b0; datain = 1'b0; din_valid = 1'b0; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_out_valid",  16'(out_valid),  16'd0);
      check("rst_data_out",   16'(data_out),   16'd0);
      check("rst_err_single", 16'(err_single), 16'd0);
      check("rst_err_double", 16'(err_double), 16'd0);
      check("rst_syndrome",   16'(syndrome),   16'd0);
      check("rst_overrun",    16'(overrun),    16'd0);
      tick();
      rst_n = 1'b1;
      out_ready = 1'b1;

      // Directed words from the feature list.
      send_word(16'h0000, 0); expect_word("clean0", 16'h0000);
      send_word(16'hFFFF, 0); expect_word("cleanF", 16'hFFFF);
      send_word(16'h0040, 0); expect_word("sgl_d6", 16'h0040);
      send_word(16'hFFFE, 0); expect_word("sgl_p0", 16'hFFFE);
      send_word(16'hFEFF, 0); expect_word("sgl_c8", 16'hFEFF);
      send_word(16'h0028, 0); expect_word("dbl_35", 16'h0028);

      // Random data, 0/1/2 injected errors, random gaps between bits.
      for (int n = 0; n < 24; n++) begin
         cw   = encode(11'($urandom));
         nerr = $urandom_range(0, 2);
         p1   = $urandom_range(0, 15);
         p2   = (p1 + $urandom_range(1, 15)) % 16;
         if (nerr >= 1) cw[p1] = ~cw[p1];
         if (nerr == 2) cw[p2] = ~cw[p2];
         send_word(cw, 1);
         expect_word("rand", cw);
      end
      check("rand_no_overrun", 16'(ovr_cnt), 16'd0);

      // Back-to-back with the consumer stalled: second word dropped.
      tick();
      out_ready = 1'b0;
      ovr_cnt   = 0;
      w1 = encode(11'($urandom));
      w2 = encode(11'($urandom)) ^ 16'h0200;
      send_bits(w1, 0);
      send_bits(w2, 0);
      din_valid = 1'b0;
      @(negedge clk); check("ovr_before", 16'(overrun), 16'd0);
      @(negedge clk); check("ovr_pulse",  16'(overrun), 16'd1);
      @(negedge clk); check("ovr_after",  16'(overrun), 16'd0);
      check("ovr_count",     16'(ovr_cnt),   16'd1);
      check("held_valid",    16'(out_valid), 16'd1);
      check("held_data",     16'(data_out),  16'(model(w1).data));
      tick();
      out_ready = 1'b1;
      expect_word("held", w1);
      repeat (30) @(negedge clk);
      check("held_only_one", 16'(got.size()), 16'd0);

      // Back-to-back with the consumer ready: both words, no overrun.
      ovr_cnt = 0;
      w1 = encode(11'($urandom));
      w2 = encode(11'($urandom)) ^ 16'h0011;
      tick();
      send_bits(w1, 0);
      send_bits(w2, 0);
      din_valid = 1'b0;
      expect_word("b2b_first",  w1);
      expect_word("b2b_second", w2);
      check("b2b_no_overrun", 16'(ovr_cnt), 16'd0);

      // Reset while a word is held and another is half received.
      out_ready = 1'b0;
      send_word(encode(11'h2A5), 0);
      for (int i = 0; i < 40 && !out_valid; i++) @(negedge clk);
      check("pre_rst_held", 16'(out_valid), 16'd1);
      tick();
      for (int i = 0; i < 7; i++) begin
         datain = 1'($urandom); din_valid = 1'b1; tick();
      end
      din_valid = 1'b0;
      rst_n     = 1'b0;
      #1;
      check("async_rst_valid", 16'(out_valid), 16'd0);
      check("async_rst_data",  16'(data_out),  16'd0);
      tick();
      rst_n     = 1'b1;
      out_ready = 1'b1;
      send_word(16'hFFFF, 0);
      expect_word("post_rst", 16'hFFFF);
      repeat (30) @(negedge clk);
      check("post_rst_only_one", 16'(got.size()), 16'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule

// File: doc/hamming_secded_decoder.md
# hamming_secded_decoder

Serial-input decoder for the 16-bit extended Hamming (SECDED) codeword produced by the team's serial Hamming encoder. It accepts one codeword bit per qualified clock, accumulates the syndrome and overall parity on the fly, corrects any single-bit error and detects double-bit errors. It then presents the 11 data bits in parallel behind a valid/ready handshake. The block sits at the receive end of the serial link, between the line deserialiser and the consumer of data words.

## Interface
- No parameters; the code is fixed (16,11) extended Hamming, even parity.
- clk  input  1  system clock; all state updates on its rising edge
- rst_n  input  1  asynchronous, active-low reset
- datain  input  1  serial codeword bit
- din_valid  input  1  datain is sampled on a rising edge only when din_valid=1
- data_out  output  11  corrected data word
- out_valid  output  1  data_out and status flags are valid
- out_ready  input  1  consumer accepts the word on an edge where out_valid=1 and out_ready=1
- err_single  output  1  the word had a single-bit error, which has been corrected (qualified by out_valid)
- err_double  output  1  an uncorrectable double error was detected (qualified by out_valid)
- syndrome  output  4  raw syndrome of the word held in data_out (qualified by out_valid)
- overrun  output  1  one-cycle pulse: a completed word was dropped

## Operation
- Codeword bits arrive in index order 0,1,…,15, with bit 0 first.
  - Bit 0 is overall parity.
  - Bits 1, 2, 4 and 8 are check bits.
  - Data bits occupy positions 3,5,6,7,9,10,11,12,13,14,15, which map to data_out[0]…data_out[10] in ascending order.
- A 4-bit bit counter (0–15) advances on each sampled bit and wraps 15→0. The sampled bit is stored at codeword[counter].
- Syndrome accumulator: on each sampled bit equal to 1 at index i, s ^= i (4 bits). The accumulator clears at the start of each word.
- Overall parity accumulator: p ^= datain over all 16 bits.
- On sampling bit 15, the word is complete and evaluated using final s and p:
  - s=0, p=0: no error. err_single=0, err_double=0.
  - p=1: single error at position s (s=0 means bit 0 itself). Invert codeword[s], then extract. err_single=1.
  - s≠0, p=0: double error. Extract the data uncorrected. err_double=1.
- Output register: data_out, err_single, err_double and syndrome load together.
  - A load occurs only if out_valid=0 or out_ready=1 on the same edge; simultaneous consume and load is allowed.
  - Otherwise the completed word is discarded and overrun pulses for one cycle. The held word is unchanged.
- The accumulators, counter and codeword storage reset for the next word. Receiving the next word is never stalled.

## Timing
- Reset (async assert, applied immediately) gives:
  - out_valid=0, data_out=0, err_single=0, err_double=0, syndrome=0, overrun=0.
  - Counter=0; accumulators cleared.
  - Any partial word is discarded. After release, the next sampled bit is treated as bit 0.
- Latency: bit 15 is sampled at edge E. The evaluation is registered, so out_valid (and the loaded flags) are high after edge E+1.
- Back-to-back words are supported: bit 0 of the next word may be sampled at edge E+1. Evaluation state must not alias with the incoming word.
- out_valid falls on the edge where the handshake completes, unless a new word loads on that same edge, in which case it stays high.
- din_valid=0 holds all receive state; gaps of any length between bits are legal.
- overrun is high for exactly the cycle following the drop edge.

## Test plan
- Clean words:
  - Stimulus: codeword 16'h0000, then 16'hFFFF.
  - Response: data_out=11'h000, then 11'h7FF. err_single=0, err_double=0, syndrome=0.
- Single data error:
  - Stimulus: 16'h0000 with bit 6 flipped.
  - Response: data_out=11'h000, err_single=1, syndrome=6.
- Check/parity bit errors:
  - Stimulus: 16'hFFFF with bit 0 flipped.
  - Response: data_out=11'h7FF, err_single=1, syndrome=0.
  - Stimulus: 16'hFFFF with bit 8 flipped.
  - Response: data_out=11'h7FF, syndrome=8.
- Double error:
  - Stimulus: 16'h0000 with bits 3 and 5 flipped.
  - Response: err_double=1, err_single=0, syndrome=6, data_out=11'h003 (uncorrected).
- Handshake and overrun:
  - Stimulus: send two words back-to-back with continuous din_valid and out_ready=0.
  - Response: the first word is held. overrun pulses one cycle after bit 15 of the second word. Raising out_ready then yields the first word only.
  - Stimulus: repeat with out_ready=1.
  - Response: both words are delivered with no overrun.
- Reset mid-word:
  - Stimulus: assert rst_n=0 after 7 bits, release, then send a full 16'hFFFF.
  - Response: exactly one word, data_out=11'h7FF with no error flags.
